vedic_mult_seq: RTL and testbench
=================================

// Module: vedic_mult_seq
// PURPOSE
//   Sequencer that builds a WIDTH x WIDTH unsigned product from one shared
//   HALF x HALF combinational vedic multiplier core (XOR/AND half-adder tree)
//   that sits outside this block.
//   - Drives the core through four partial products (LL, LH, HL, HH).
//   - Shift-accumulates the partial products into a 2*WIDTH result.
//   - Handshakes operands in and the product out with valid/ready.
//   Sits between operand producers and the multiplier core in the vedic datapath.
// PARAMETERS
//   WIDTH      8   operand width; must be even, >= 4
//   SKIP_ZERO  0   1 = skip partial-product steps whose core operand half is zero
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        operands a/b valid
//   in_ready   out  1        block can accept operands (high only in IDLE)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   core_a     out  WIDTH/2  operand half to shared core
//   core_b     out  WIDTH/2  operand half to shared core
//   core_p     in   WIDTH    combinational core product core_a*core_b
//   out_valid  out  1        product valid
//   out_ready  in   1        consumer accepts product
//   product    out  2*WIDTH  a*b, held stable while out_valid
//   busy       out  1        high in MUL and DONE
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0, busy=0, product=0, core_a=core_b=0.
//     Operand regs, accumulator and step counter clear to 0.
//   States: IDLE -> MUL -> DONE -> IDLE.
//   IDLE
//     - in_valid&in_ready at an edge: latch a/b, clear accumulator, enter MUL.
//     - First step is LL, or the first non-skipped step when SKIP_ZERO=1.
//     - core_a/core_b driven 0.
//   MUL: one step per cycle, in order:
//       LL  core_a=aL, core_b=bL, shift 0
//       LH  core_a=aL, core_b=bH, shift HALF
//       HL  core_a=aH, core_b=bL, shift HALF
//       HH  core_a=aH, core_b=bH, shift WIDTH
//     - core_a/core_b come from latched operands and step only (glitch-free within the cycle).
//     - At each step's closing edge: acc <= acc + (core_p << shift), 2*WIDTH bits.
//     - No overflow is possible: the exact product fits in 2*WIDTH bits.
//     - After the last executed step: product <= final acc, enter DONE.
//   SKIP_ZERO=1
//     - A step is skipped when either operand half it uses is zero; it costs no cycle.
//     - If every step skips (a==0 or b==0): IDLE -> DONE directly, product=0.
//   DONE
//     - out_valid=1; product held until out_valid&out_ready at an edge, then IDLE.
//     - in_ready is low in DONE, so no overlap with the next operation.
//   Latency (SKIP_ZERO=0): accept edge at cycle 0, MUL in cycles 1-4, out_valid
//     in cycle 5. Minimum issue interval is 6 cycles.
//   in_valid outside IDLE is ignored; a and b may change freely while busy.
//   out_ready outside DONE is ignored.
//   Reset asserted mid-operation: immediate return to reset values; the
//     partial result is discarded and no out_valid is produced.
// TESTING
//   1. SKIP_ZERO=0, a=0xFF, b=0xFF, out_ready=1 -> out_valid in cycle 5,
//      product=0xFE01. Core sees (F,F) in each of cycles 1-4.
//   2. a=0x12, b=0x34 -> core pairs (2,4),(2,3),(1,4),(1,3), product=0x03A8.
//   3. Backpressure: out_ready=0 for 10 cycles after out_valid -> product and
//      out_valid stable, in_ready=0. Raising out_ready gives IDLE on the next cycle.
//   4. in_valid pulsed with a=0x77 during MUL of test 2 -> ignored, product still 0x03A8.
//   5. Reset pulsed at cycle 3 of an operation -> all outputs at reset values.
//      Next op 0x05*0x03 gives product=0x000F.
//   6. SKIP_ZERO=1: a=0x0F, b=0x0F -> only LL executes, out_valid in cycle 2,
//      product=0x00E1. a=0x00, b=0x5A -> DONE in cycle 1, product=0.

Source files
------------

// File: rtl/vedic_mult_seq.sv
// Sequences one shared HALF x HALF core through four partial products and
// shift-accumulates them into a 2*WIDTH product with valid/ready handshakes.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for operands, in_ready high, core driven to zero
// S_MUL  | one partial product per cycle (LL, LH, HL, HH), accumulating
// S_DONE | product presented with out_valid until out_ready
module vedic_mult_seq #(
    parameter int WIDTH     = 8,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH/2-1:0]   core_a,
    output logic [WIDTH/2-1:0]   core_b,
    input  logic [WIDTH-1:0]     core_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     pp_ext;
    logic [1:0]        step;
    logic [2:0]        first_step;
    logic [2:0]        cont_step;

    // Bit i set when step i (0=LL 1=LH 2=HL 3=HH) must execute.
    function automatic logic [3:0] live_mask(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        logic xl, xh, yl, yh;
        xl = |x[HALF-1:0];
        xh = |x[WIDTH-1:HALF];
        yl = |y[HALF-1:0];
        yh = |y[WIDTH-1:HALF];
        if (!SKIP_ZERO)
            return 4'b1111;
        return {xh & yh, xh & yl, xl & yh, xl & yl};
    endfunction

    // Returns {found, index} of the lowest live step at or above 'from'.
    function automatic logic [2:0] next_live(input logic [3:0] mask,
                                             input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && mask[i])
                r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_step = next_live(live_mask(a, b), 3'd0);
    assign cont_step  = next_live(live_mask(a_q, b_q), {1'b0, step} + 3'd1);

    assign pp_ext = {{WIDTH{1'b0}}, core_p};

    always_comb begin
        acc_sum = acc;
        case (step)
            2'd0:    acc_sum = acc + pp_ext;
            2'd1,
            2'd2:    acc_sum = acc + (pp_ext << HALF);
            default: acc_sum = acc + (pp_ext << WIDTH);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        core_a    = '0;
        core_b    = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = first_step[2] ? S_MUL : S_DONE;
            end
            S_MUL: begin
                busy = 1'b1;
                // Core operands come only from registers so they settle once per cycle.
                case (step)
                    2'd0: begin core_a = a_q[HALF-1:0];     core_b = b_q[HALF-1:0];     end
                    2'd1: begin core_a = a_q[HALF-1:0];     core_b = b_q[WIDTH-1:HALF]; end
                    2'd2: begin core_a = a_q[WIDTH-1:HALF]; core_b = b_q[HALF-1:0];     end
                    default: begin core_a = a_q[WIDTH-1:HALF]; core_b = b_q[WIDTH-1:HALF]; end
                endcase
                if (!cont_step[2])
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            step    <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc     <= '0;
                        step    <= first_step[1:0];
                        product <= '0;
                    end
                end
                S_MUL: begin
                    acc <= acc_sum;
                    if (cont_step[2])
                        step <= cont_step[1:0];
                    else
                        product <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq: one instance without and one with zero-skipping,
// each wired to a behavioural HALF x HALF core.
module tb_vedic_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b, core_p;
    logic [3:0]  core_a, core_b;
    logic [15:0] product;

    logic        in_valid_z, in_ready_z, out_valid_z, out_ready_z, busy_z;
    logic [7:0]  a_z, b_z, core_p_z;
    logic [3:0]  core_a_z, core_b_z;
    logic [15:0] product_z;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign core_p   = {4'b0, core_a} * {4'b0, core_b};
    assign core_p_z = {4'b0, core_a_z} * {4'b0, core_b_z};

    vedic_mult_seq #(.WIDTH(8), .SKIP_ZERO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .core_a(core_a), .core_b(core_b), .core_p(core_p),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    vedic_mult_seq #(.WIDTH(8), .SKIP_ZERO(1'b1)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_z), .in_ready(in_ready_z),
        .a(a_z), .b(b_z), .core_a(core_a_z), .core_b(core_b_z), .core_p(core_p_z),
        .out_valid(out_valid_z), .out_ready(out_ready_z), .product(product_z), .busy(busy_z)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents operands for one edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_z(input logic [7:0] av, input logic [7:0] bv);
        in_valid_z = 1'b1;
        a_z        = av;
        b_z        = bv;
        @(negedge clk);
        in_valid_z = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_a [4];
        logic [3:0] exp_b [4];

        rst_n       = 1'b0;
        in_valid    = 1'b0; a   = '0; b   = '0; out_ready   = 1'b1;
        in_valid_z  = 1'b0; a_z = '0; b_z = '0; out_ready_z = 1'b1;
        repeat (2) @(negedge clk);

        check_val("rst_in_ready",  in_ready,  1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_busy",      busy,      1'b0);
        check_val("rst_product",   product,   16'h0000);
        check_val("rst_core_a",    core_a,    4'h0);
        check_val("rst_core_b",    core_b,    4'h0);

        rst_n = 1'b1;
        @(negedge clk);

        // 0xFF * 0xFF
        issue(8'hFF, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("ff_core_a_c%0d", k + 1), core_a, 4'hF);
            check_val($sformatf("ff_core_b_c%0d", k + 1), core_b, 4'hF);
            check_val($sformatf("ff_busy_c%0d", k + 1), busy, 1'b1);
            check_val($sformatf("ff_out_valid_c%0d", k + 1), out_valid, 1'b0);
            @(negedge clk);
        end
        check_val("ff_out_valid_c5", out_valid, 1'b1);
        check_val("ff_product",      product,   16'hFE01);
        @(negedge clk);
        check_val("ff_idle_in_ready", in_ready, 1'b1);
        check_val("ff_idle_valid",    out_valid, 1'b0);

        // 0x12 * 0x34 with a stray in_valid during MUL and output backpressure
        exp_a = '{4'h2, 4'h2, 4'h1, 4'h1};
        exp_b = '{4'h4, 4'h3, 4'h4, 4'h3};
        out_ready = 1'b0;
        issue(8'h12, 8'h34);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("p2_core_a_c%0d", k + 1), core_a, exp_a[k]);
            check_val($sformatf("p2_core_b_c%0d", k + 1), core_b, exp_b[k]);
            if (k == 0) begin
                in_valid = 1'b1;
                a        = 8'h77;
                b        = 8'h77;
            end
            if (k == 1) begin
                in_valid = 1'b0;
                a        = 8'hA5;
                b        = 8'h5A;
            end
            @(negedge clk);
        end
        check_val("p2_out_valid", out_valid, 1'b1);
        check_val("p2_product",   product,   16'h03A8);
        check_val("p2_in_ready",  in_ready,  1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_val($sformatf("bp_out_valid_%0d", k), out_valid, 1'b1);
            check_val($sformatf("bp_product_%0d", k),   product,   16'h03A8);
            check_val($sformatf("bp_in_ready_%0d", k),  in_ready,  1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release_in_ready", in_ready,  1'b1);
        check_val("bp_release_valid",    out_valid, 1'b0);

        // Reset in cycle 3 of an operation
        issue(8'h12, 8'h34);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready",  in_ready,  1'b1);
        check_val("mid_rst_out_valid", out_valid, 1'b0);
        check_val("mid_rst_busy",      busy,      1'b0);
        check_val("mid_rst_product",   product,   16'h0000);
        check_val("mid_rst_core_a",    core_a,    4'h0);
        check_val("mid_rst_core_b",    core_b,    4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_no_valid", out_valid, 1'b0);

        issue(8'h05, 8'h03);
        repeat (4) @(negedge clk);
        check_val("p5_out_valid", out_valid, 1'b1);
        check_val("p5_product",   product,   16'h000F);
        @(negedge clk);

        // Zero-skipping instance
        issue_z(8'h0F, 8'h0F);
        check_val("z_core_a_c1",    core_a_z,    4'hF);
        check_val("z_core_b_c1",    core_b_z,    4'hF);
        check_val("z_out_valid_c1", out_valid_z, 1'b0);
        @(negedge clk);
        check_val("z_out_valid_c2", out_valid_z, 1'b1);
        check_val("z_product",      product_z,   16'h00E1);
        @(negedge clk);
        check_val("z_idle_in_ready", in_ready_z, 1'b1);

        issue_z(8'h00, 8'h5A);
        check_val("z0_out_valid_c1", out_valid_z, 1'b1);
        check_val("z0_product",      product_z,   16'h0000);
        check_val("z0_core_a",       core_a_z,    4'h0);
        @(negedge clk);
        check_val("z0_idle_in_ready", in_ready_z, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
